ram_addr_gen_nram: RTL and testbench
====================================

RAM_ADDR_GEN_NRAM -- requirements
Module: ram_addr_gen_nram

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: "clk" is the clock and "rst" is the asynchronous active-low reset.
REQ-002 Parameter N_CH, default 5, SHALL set the number of RAM channels served in parallel.
REQ-003 Parameter CW, default 14, SHALL set the coordinate width, fixed point.
REQ-004 Parameter FRAC, default 4, SHALL set the number of fractional coordinate bits.
REQ-005 Parameter AW, default 15, SHALL set the RAM address width.
REQ-006 Parameter LINE_W, default 180, SHALL set the pixels per image line.
REQ-007 Parameter N_ROWS, default 150, SHALL set the image lines.
REQ-008 Parameter LOAD_WORDS, default 13500 (LINE_W*N_ROWS/2), SHALL set the number of load beats per frame.
REQ-009 Port clk, input, 1 bit: clock.
REQ-010 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-011 Port start, input, 1 bit: level; high runs a frame, low aborts.
REQ-012 Port ld_valid, input, 1 bit: one load beat (two pixels) is present this cycle.
REQ-013 Ports pt_xi and pt_yi, input, N_CH*CW bits each: port-A coordinates; channel k occupies bits [(k+1)*CW-1 -: CW].
REQ-014 Ports pt_xo and pt_yo, input, N_CH*CW bits each: port-B coordinates, packed the same way.
REQ-015 Port pt_valid, input, 1 bit: the coordinate set is valid.
REQ-016 Port pt_ready, output, 1 bit: a coordinate set is accepted when pt_valid and pt_ready are both high.
REQ-017 Ports addr_a and addr_b, output, N_CH*AW bits each: per-channel port addresses.
REQ-018 Ports we_a_n and we_b_n, output, 1 bit each: active-low write enables, shared by all channels.
REQ-019 Port rd_valid, output, 1 bit: read addresses on addr_a/addr_b are valid this cycle.
REQ-020 Port oob, output, N_CH*2 bits: per-channel out-of-range flags, bit 2k = port A, bit 2k+1 = port B, valid with rd_valid.
REQ-021 Port state_o, output, 2 bits: IDLE=0, LOAD=1, READ=2.
REQ-022 Port frame_done, output, 1 bit: single-cycle pulse on the LOAD->READ transition.

Function
REQ-023 The FSM SHALL go IDLE->LOAD when start is high; code 3 is illegal and SHALL recover to IDLE on the next clock.
REQ-024 In LOAD, each cycle with ld_valid high SHALL produce, combinationally from the beat counter cnt: we_a_n=we_b_n=0, addr_a={cnt,0} and addr_b={cnt,1} on every channel, then increment cnt.
REQ-025 In LOAD with ld_valid low, we_a_n and we_b_n SHALL be 1 and cnt SHALL hold.
REQ-026 On the beat where cnt==LOAD_WORDS-1 and ld_valid is high, the FSM SHALL go to READ next cycle, pulse frame_done for one cycle, and clear cnt.
REQ-027 In LOAD or READ, start low SHALL force IDLE next cycle, clear cnt, flush the pipeline (rd_valid=0), and assert no frame_done.
REQ-028 pt_ready SHALL equal (state==READ); the block applies no downstream backpressure.
REQ-029 The read pipeline SHALL have 2 stages: stage 1 registers the integer parts x=coord[CW-1:FRAC] and y likewise, plus clamp flags; stage 2 registers addr = y*LINE_W + x truncated to AW bits; rd_valid is asserted exactly 2 cycles after acceptance.
REQ-030 Clamping SHALL be applied per channel and per port: x >= LINE_W becomes LINE_W-1, y >= N_ROWS becomes N_ROWS-1, and the matching oob bit is set.
REQ-031 The multiply SHALL be unsigned with an intermediate width of at least CW-FRAC+8 bits and no overflow before truncation.
REQ-032 In READ, we_a_n and we_b_n SHALL stay 1; when rd_valid is 0, addr_a, addr_b and oob SHALL hold their last values.
REQ-033 Back-to-back acceptances SHALL give back-to-back rd_valid, at full throughput of 1 set per cycle.
REQ-034 In IDLE, pt_valid and ld_valid SHALL be ignored.

Reset
REQ-035 While rst=0, asynchronously: state=IDLE, cnt=0, pipeline valids=0, addr_a=addr_b=0, oob=0, we_a_n=we_b_n=1, rd_valid=0, frame_done=0.
REQ-036 Reset deassertion SHALL take effect synchronously at the next clk edge; an assertion mid-LOAD or mid-READ SHALL discard all progress.

Verification
REQ-037 Full load: start=1 with ld_valid held high for 13500 cycles -> beat 0 gives addr_a=0 and addr_b=1; beat 13499 gives addr_a=0x6976 and addr_b=0x6977; one frame_done pulse; state=READ.
REQ-038 Read latency: channel 2 xi=0x0150 (21), yi=0x00A0 (10) -> two cycles later addr_a chunk 2 = 1821, oob=0, rd_valid=1.
REQ-039 Clamp: xi=0x0C80 (200), yi=0x0FA0 (250) -> address 149*180+179 = 26999 and oob port-A bit set.
REQ-040 Abort: start dropped at beat 5000 -> IDLE next cycle; a new start restarts at addr_a=0 with no frame_done.
REQ-041 Gapped load: ld_valid toggled at random -> cnt advances only on valid beats and we_*_n is low only on those cycles.
REQ-042 Async reset mid-READ with pipeline full -> outputs cleared immediately, no rd_valid after release.

Source files
------------

// File: rtl/ram_addr_gen_nram.sv
// Address generator for N_CH parallel RAM channels: streams write addresses while a
// frame is loaded, then turns coordinate sets into clamped read addresses through a two-stage pipeline.
module ram_addr_gen_nram #(
   parameter int N_CH       = 5,
   parameter int CW         = 14,
   parameter int FRAC       = 4,
   parameter int AW         = 15,
   parameter int LINE_W     = 180,
   parameter int N_ROWS     = 150,
   parameter int LOAD_WORDS = 13500
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 ld_valid,
   input  logic [N_CH*CW-1:0]   pt_xi,
   input  logic [N_CH*CW-1:0]   pt_yi,
   input  logic [N_CH*CW-1:0]   pt_xo,
   input  logic [N_CH*CW-1:0]   pt_yo,
   input  logic                 pt_valid,
   output logic                 pt_ready,
   output logic [N_CH*AW-1:0]   addr_a,
   output logic [N_CH*AW-1:0]   addr_b,
   output logic                 we_a_n,
   output logic                 we_b_n,
   output logic                 rd_valid,
   output logic [N_CH*2-1:0]    oob,
   output logic [1:0]           state_o,
   output logic                 frame_done
);

   // state  | meaning
   // IDLE   | waiting for start; load beats and coordinate sets ignored
   // LOAD   | one write beat (two pixels) per ld_valid, beat counter advances
   // READ   | coordinate sets accepted every cycle, addresses 2 cycles later
   // 3      | illegal, returns to IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_READ = 2'd2;

   localparam int XW   = CW - FRAC;
   localparam int MW   = XW + 9;
   localparam int CNTW = AW - 1;

   logic [1:0]                  r_state;
   logic [CNTW-1:0]             r_cnt;
   logic                        r_frame_done;
   logic                        r_v1;
   logic                        r_v2;
   logic [N_CH-1:0][XW-1:0]     r_xa;
   logic [N_CH-1:0][XW-1:0]     r_ya;
   logic [N_CH-1:0][XW-1:0]     r_xb;
   logic [N_CH-1:0][XW-1:0]     r_yb;
   logic [N_CH-1:0][1:0]        r_oob1;
   logic [N_CH*AW-1:0]          r_addr_a;
   logic [N_CH*AW-1:0]          r_addr_b;
   logic [N_CH*2-1:0]           r_oob;

   logic                        w_abort;
   logic                        w_beat;
   logic                        w_last;
   logic                        w_accept;
   logic [AW-1:0]               w_ld_a;
   logic [AW-1:0]               w_ld_b;
   logic [N_CH-1:0][XW:0]       w_cxa;
   logic [N_CH-1:0][XW:0]       w_cya;
   logic [N_CH-1:0][XW:0]       w_cxb;
   logic [N_CH-1:0][XW:0]       w_cyb;
   logic [N_CH*AW-1:0]          w_addr_a;
   logic [N_CH*AW-1:0]          w_addr_b;

   // Top bit of the result flags a clamp; lower bits are the clamped integer part.
   function automatic logic [XW:0] clamp_c(input logic [CW-1:0] c, input int lim);
      logic [XW-1:0] v;
      v = c[CW-1:FRAC];
      if (int'(v) >= lim) clamp_c = {1'b1, XW'(lim - 1)};
      else                clamp_c = {1'b0, v};
   endfunction

   function automatic logic [AW-1:0] lin_addr(input logic [XW-1:0] x, input logic [XW-1:0] y);
      logic [MW-1:0] p;
      p = MW'(y) * MW'(LINE_W) + MW'(x);
      lin_addr = AW'(p);
   endfunction

   assign w_abort  = ((r_state == S_LOAD) || (r_state == S_READ)) && !start;
   assign w_beat   = (r_state == S_LOAD) && ld_valid;
   assign w_last   = w_beat && (r_cnt == CNTW'(LOAD_WORDS - 1));
   assign w_accept = pt_valid && pt_ready;
   assign w_ld_a   = {r_cnt, 1'b0};
   assign w_ld_b   = {r_cnt, 1'b1};

   assign pt_ready   = (r_state == S_READ);
   assign state_o    = r_state;
   assign frame_done = r_frame_done;
   assign rd_valid   = r_v2;
   assign oob        = r_oob;
   assign we_a_n     = !w_beat;
   assign we_b_n     = !w_beat;
   assign addr_a     = (r_state == S_LOAD) ? {N_CH{w_ld_a}} : r_addr_a;
   assign addr_b     = (r_state == S_LOAD) ? {N_CH{w_ld_b}} : r_addr_b;

   always_comb begin
      w_cxa = '0;
      w_cya = '0;
      w_cxb = '0;
      w_cyb = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_cxa[k] = clamp_c(pt_xi[k*CW +: CW], LINE_W);
         w_cya[k] = clamp_c(pt_yi[k*CW +: CW], N_ROWS);
         w_cxb[k] = clamp_c(pt_xo[k*CW +: CW], LINE_W);
         w_cyb[k] = clamp_c(pt_yo[k*CW +: CW], N_ROWS);
      end
   end

   always_comb begin
      w_addr_a = '0;
      w_addr_b = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_addr_a[k*AW +: AW] = lin_addr(r_xa[k], r_ya[k]);
         w_addr_b[k*AW +: AW] = lin_addr(r_xb[k], r_yb[k]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) r_state <= S_LOAD;
            end
            S_LOAD: begin
               if (!start) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (w_last) begin
                  r_state      <= S_READ;
                  r_cnt        <= '0;
                  r_frame_done <= 1'b1;
               end else if (w_beat) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_READ: begin
               if (!start) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // An abort drops anything in flight so no stale rd_valid leaks into the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_xa     <= '0;
         r_ya     <= '0;
         r_xb     <= '0;
         r_yb     <= '0;
         r_oob1   <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_oob    <= '0;
      end else begin
         r_v1 <= w_accept && !w_abort;
         r_v2 <= r_v1 && !w_abort;
         if (w_accept && !w_abort) begin
            for (int k = 0; k < N_CH; k++) begin
               r_xa[k]   <= w_cxa[k][XW-1:0];
               r_ya[k]   <= w_cya[k][XW-1:0];
               r_xb[k]   <= w_cxb[k][XW-1:0];
               r_yb[k]   <= w_cyb[k][XW-1:0];
               r_oob1[k] <= {w_cxb[k][XW] | w_cyb[k][XW], w_cxa[k][XW] | w_cya[k][XW]};
            end
         end
         if (r_v1 && !w_abort) begin
            r_addr_a <= w_addr_a;
            r_addr_b <= w_addr_b;
            r_oob    <= r_oob1;
         end
      end
   end

endmodule

// File: tb/tb_ram_addr_gen_nram.sv
// Scoreboard bench for ram_addr_gen_nram: drivers queue expected write beats and read results,
// a negedge monitor pops and compares whenever the DUT presents a write or a read.
module tb_ram_addr_gen_nram;

   localparam int N_CH       = 5;
   localparam int CW         = 14;
   localparam int FRAC       = 4;
   localparam int AW         = 15;
   localparam int LINE_W     = 180;
   localparam int N_ROWS     = 150;
   localparam int LOAD_WORDS = 13500;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic                 ld_valid;
   logic [N_CH*CW-1:0]   pt_xi, pt_yi, pt_xo, pt_yo;
   logic                 pt_valid;
   logic                 pt_ready;
   logic [N_CH*AW-1:0]   addr_a, addr_b;
   logic                 we_a_n, we_b_n;
   logic                 rd_valid;
   logic [N_CH*2-1:0]    oob;
   logic [1:0]           state_o;
   logic                 frame_done;

   ram_addr_gen_nram #(
      .N_CH(N_CH), .CW(CW), .FRAC(FRAC), .AW(AW),
      .LINE_W(LINE_W), .N_ROWS(N_ROWS), .LOAD_WORDS(LOAD_WORDS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid),
      .pt_xi(pt_xi), .pt_yi(pt_yi), .pt_xo(pt_xo), .pt_yo(pt_yo),
      .pt_valid(pt_valid), .pt_ready(pt_ready),
      .addr_a(addr_a), .addr_b(addr_b), .we_a_n(we_a_n), .we_b_n(we_b_n),
      .rd_valid(rd_valid), .oob(oob), .state_o(state_o), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N_CH*AW-1:0] a;
      logic [N_CH*AW-1:0] b;
      logic [N_CH*2-1:0]  o;
      int                 c;
   } rexp_t;

   rexp_t              rq[$];
   int                 lq[$];
   int                 cyc = 0;
   int                 n_vec = 0;
   int                 n_err = 0;
   int                 fd_cnt = 0;
   int                 exp_cnt = 0;
   bit                 in_read = 0;
   logic [N_CH*AW-1:0] last_a = '0;
   logic [N_CH*AW-1:0] last_b = '0;
   logic [N_CH*2-1:0]  last_o = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Reference: integer part of the fixed-point coordinate, clamped to the image, row-major address.
   function automatic int ref_addr(input int cx, input int cy, output bit of);
      int x, y;
      x  = cx / (1 << FRAC);
      y  = cy / (1 << FRAC);
      of = 1'b0;
      if (x >= LINE_W) begin x = LINE_W - 1; of = 1'b1; end
      if (y >= N_ROWS) begin y = N_ROWS - 1; of = 1'b1; end
      return y * LINE_W + x;
   endfunction

   function automatic rexp_t model(input logic [N_CH*CW-1:0] xi, input logic [N_CH*CW-1:0] yi,
                                   input logic [N_CH*CW-1:0] xo, input logic [N_CH*CW-1:0] yo);
      rexp_t e;
      bit    fa, fb;
      int    aa, ab;
      e.a = '0; e.b = '0; e.o = '0; e.c = 0;
      for (int k = 0; k < N_CH; k++) begin
         aa = ref_addr(int'(xi[k*CW +: CW]), int'(yi[k*CW +: CW]), fa);
         ab = ref_addr(int'(xo[k*CW +: CW]), int'(yo[k*CW +: CW]), fb);
         e.a[k*AW +: AW] = AW'(aa);
         e.b[k*AW +: AW] = AW'(ab);
         e.o[2*k]        = fa;
         e.o[2*k+1]      = fb;
      end
      return e;
   endfunction

   function automatic logic [CW-1:0] rnd_coord(input int lim);
      if ($urandom_range(0, 1) == 1)
         return CW'(($urandom_range(0, lim - 1) << FRAC) | $urandom_range(0, (1 << FRAC) - 1));
      return CW'($urandom);
   endfunction

   function automatic logic [N_CH*CW-1:0] rvec(input int lim);
      logic [N_CH*CW-1:0] v;
      v = '0;
      for (int k = 0; k < N_CH; k++) v[k*CW +: CW] = rnd_coord(lim);
      return v;
   endfunction

   always @(negedge clk) begin : monitor
      int    b;
      rexp_t e;
      if (rst) begin
         if (frame_done) fd_cnt++;
         if (!we_a_n || !we_b_n) begin
            if (lq.size() == 0) begin
               chk("unexpected_write", 128'({we_a_n, we_b_n}), 128'(2'b11));
            end else begin
               b = lq.pop_front();
               chk("load_we_pair", 128'({we_a_n, we_b_n}), 128'(2'b00));
               chk("load_addr_a", 128'(addr_a), 128'({N_CH{AW'(2 * b)}}));
               chk("load_addr_b", 128'(addr_b), 128'({N_CH{AW'(2 * b + 1)}}));
            end
         end
         if (rd_valid) begin
            if (rq.size() == 0) begin
               chk("unexpected_rd_valid", 128'(rd_valid), 128'(0));
            end else begin
               e = rq.pop_front();
               chk("rd_latency", 128'(cyc), 128'(e.c));
               chk("rd_addr_a", 128'(addr_a), 128'(e.a));
               chk("rd_addr_b", 128'(addr_b), 128'(e.b));
               chk("rd_oob", 128'(oob), 128'(e.o));
               last_a = e.a;
               last_b = e.b;
               last_o = e.o;
            end
         end else if (state_o == 2'd2) begin
            chk("hold_addr_a", 128'(addr_a), 128'(last_a));
            chk("hold_addr_b", 128'(addr_b), 128'(last_b));
            chk("hold_oob", 128'(oob), 128'(last_o));
         end
      end
   end

   task automatic do_load(input int target, input int pct);
      int guard;
      guard = 0;
      while (exp_cnt < target && guard < 20 * target + 100) begin
         @(posedge clk); #1;
         guard++;
         if ($urandom_range(0, 99) < pct) begin
            ld_valid = 1'b1;
            lq.push_back(exp_cnt);
            exp_cnt++;
         end else begin
            ld_valid = 1'b0;
         end
      end
      if (exp_cnt < target) chk("load_timeout", 128'(exp_cnt), 128'(target));
   endtask

   task automatic send(input bit v, input logic [N_CH*CW-1:0] xi, input logic [N_CH*CW-1:0] yi,
                       input logic [N_CH*CW-1:0] xo, input logic [N_CH*CW-1:0] yo);
      rexp_t e;
      @(posedge clk); #1;
      pt_valid = v;
      pt_xi = xi; pt_yi = yi; pt_xo = xo; pt_yo = yo;
      if (v && in_read) begin
         e   = model(xi, yi, xo, yo);
         e.c = cyc + 2;
         rq.push_back(e);
      end
   endtask

   initial begin : main
      logic [N_CH*CW-1:0] xi, yi;
      rst = 1'b0; start = 1'b0; ld_valid = 1'b0; pt_valid = 1'b0;
      pt_xi = '0; pt_yi = '0; pt_xo = '0; pt_yo = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_state", 128'(state_o), 128'(0));
      chk("rst_pt_ready", 128'(pt_ready), 128'(0));
      chk("rst_addr_a", 128'(addr_a), 128'(0));
      chk("rst_addr_b", 128'(addr_b), 128'(0));
      chk("rst_oob", 128'(oob), 128'(0));
      chk("rst_we", 128'({we_a_n, we_b_n}), 128'(2'b11));
      chk("rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("rst_frame_done", 128'(frame_done), 128'(0));

      // IDLE ignores load beats and coordinate sets
      @(posedge clk); #1;
      rst = 1'b1; ld_valid = 1'b1; pt_valid = 1'b1; pt_xi = rvec(LINE_W); pt_yi = rvec(N_ROWS);
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      chk("idle_state", 128'(state_o), 128'(0));
      chk("idle_pt_ready", 128'(pt_ready), 128'(0));

      // gapped load, aborted at beat 5000
      @(posedge clk); #1;
      ld_valid = 1'b0; pt_valid = 1'b0; start = 1'b1; exp_cnt = 0;
      do_load(5000, 50);
      @(posedge clk); #1;
      start = 1'b0; ld_valid = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("abort_idle", 128'(state_o), 128'(0));
      chk("abort_beats_consumed", 128'(lq.size()), 128'(0));
      chk("abort_no_frame_done", 128'(fd_cnt), 128'(0));

      // restart from beat 0 and load a full frame
      @(posedge clk); #1;
      start = 1'b1; exp_cnt = 0;
      do_load(LOAD_WORDS, 90);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      in_read = 1'b1;
      @(negedge clk); #1;
      chk("full_load_state_read", 128'(state_o), 128'(2));
      chk("full_load_frame_done_count", 128'(fd_cnt), 128'(1));
      chk("full_load_beats_consumed", 128'(lq.size()), 128'(0));
      chk("read_pt_ready", 128'(pt_ready), 128'(1));

      // in-range point on channel 2, then a clamped point on channel 0
      xi = rvec(LINE_W); yi = rvec(N_ROWS);
      xi[2*CW +: CW] = 14'h0150; yi[2*CW +: CW] = 14'h00A0;
      send(1'b1, xi, yi, rvec(LINE_W), rvec(N_ROWS));
      send(1'b0, '0, '0, '0, '0);
      send(1'b0, '0, '0, '0, '0);
      xi = rvec(LINE_W); yi = rvec(N_ROWS);
      xi[0 +: CW] = 14'h0C80; yi[0 +: CW] = 14'h0FA0;
      send(1'b1, xi, yi, rvec(LINE_W), rvec(N_ROWS));
      for (int i = 0; i < 300; i++)
         send($urandom_range(0, 99) < 70, rvec(LINE_W), rvec(N_ROWS), rvec(LINE_W), rvec(N_ROWS));
      for (int i = 0; i < 40; i++)
         send(1'b1, rvec(LINE_W), rvec(N_ROWS), rvec(LINE_W), rvec(N_ROWS));
      for (int i = 0; i < 4; i++) send(1'b0, '0, '0, '0, '0);
      @(negedge clk); #1;
      chk("read_queue_drained", 128'(rq.size()), 128'(0));
      chk("single_frame_done", 128'(fd_cnt), 128'(1));

      // async reset with the pipeline full
      for (int i = 0; i < 6; i++)
         send(1'b1, rvec(LINE_W), rvec(N_ROWS), rvec(LINE_W), rvec(N_ROWS));
      @(posedge clk); #3;
      rst = 1'b0; start = 1'b0; pt_valid = 1'b0;
      #1;
      chk("async_rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("async_rst_addr_a", 128'(addr_a), 128'(0));
      chk("async_rst_addr_b", 128'(addr_b), 128'(0));
      chk("async_rst_oob", 128'(oob), 128'(0));
      chk("async_rst_state", 128'(state_o), 128'(0));
      chk("async_rst_we", 128'({we_a_n, we_b_n}), 128'(2'b11));
      rq.delete();
      in_read = 1'b0;
      last_a = '0; last_b = '0; last_o = '0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk); #1;
      chk("post_rst_state", 128'(state_o), 128'(0));
      chk("post_rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("post_rst_frame_done_count", 128'(fd_cnt), 128'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
